// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU constants for the instruction fetch path
package fetch_unit_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 32-bit program counter register with load enable
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with decode hold stage
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] newpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        addr_err
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         pc_load;
    logic         capture;
    logic         misaligned_accept;

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (reset),
        .load  (pc_load),
        .d     (newpc),
        .q     (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // A misaligned newpc is refused: the held instruction stays offered to decode.
    always_comb begin
        state_next        = state;
        imem_req          = 1'b0;
        out_valid         = 1'b0;
        pc_load           = 1'b0;
        capture           = 1'b0;
        misaligned_accept = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (word_aligned(newpc)) begin
                        pc_load    = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        misaligned_accept = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out  <= RESET_PC;
            ins_out <= 32'h0000_0000;
        end else if (capture) begin
            pc_out  <= pc;
            ins_out <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err <= 1'b0;
        end else if (misaligned_accept) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] newpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] model_pc;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .newpc       (newpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc_out      (pc_out),
        .ins_out     (ins_out),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_pc_out"}, pc_out, e[63:32]);
            chk({tag, "_ins_out"}, ins_out, e[31:0]);
        end
    endtask

    // Request at model_pc, grant after gnt_dly cycles, data after rv_dly wait cycles.
    task automatic fetch(input string tag, input logic [31:0] data, input int gnt_dly, input int rv_dly);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, model_pc);
        sb_q.push_back({model_pc, data});
        for (int i = 0; i < gnt_dly; i++) begin
            tick();
            chk({tag, "_req_hold"}, {31'd0, imem_req}, 32'd1);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk({tag, "_wait_noreq"}, {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rv_dly; i++) begin
            tick();
            chk({tag, "_wait_nvalid"}, {31'd0, out_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        sb_pop_check(tag);
    endtask

    task automatic accept(input logic [31:0] npc);
        newpc     = npc;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (npc[1:0] == 2'b00) model_pc = npc;
    endtask

    initial begin
        reset       = 1'b0;
        newpc       = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        out_ready   = 1'b0;
        model_pc    = 32'h0000_3000;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc_out", pc_out, 32'h0000_3000);
        chk("rst_ins_out", ins_out, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0000_3000);

        fetch("f0", 32'h2408_0001, 0, 1);

        // Stall: outputs frozen, stray gnt/rvalid ignored while held.
        for (int i = 0; i < 5; i++) begin
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_0000 + i;
            newpc       = 32'h0000_5000;
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_pc", pc_out, 32'h0000_3000);
            chk("stall_ins", ins_out, 32'h2408_0001);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        accept(32'h0000_3004);
        chk("acc_req", {31'd0, imem_req}, 32'd1);
        chk("acc_addr", imem_addr, 32'h0000_3004);
        chk("acc_nvalid", {31'd0, out_valid}, 32'd0);

        fetch("f1", 32'h8C09_0004, 2, 3);

        accept(32'h0000_3002);
        chk("mis_err", {31'd0, addr_err}, 32'd1);
        chk("mis_valid", {31'd0, out_valid}, 32'd1);
        chk("mis_pc_out", pc_out, 32'h0000_3004);
        chk("mis_ins", ins_out, 32'h8C09_0004);
        chk("mis_addr", imem_addr, 32'h0000_3004);
        tick();
        chk("mis_hold", {31'd0, out_valid}, 32'd1);
        accept(32'h0000_3008);
        chk("fix_addr", imem_addr, 32'h0000_3008);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);

        // Grant and rvalid together in S_REQ: only the grant counts.
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("gr_nvalid", {31'd0, out_valid}, 32'd0);
        chk("gr_noreq", {31'd0, imem_req}, 32'd0);
        sb_q.push_back({32'h0000_3008, 32'h0140_2020});
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0140_2020;
        tick();
        imem_rvalid = 1'b0;
        sb_pop_check("gr");

        // Reset while a fetch is outstanding.
        accept(32'h0000_300C);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_err", {31'd0, addr_err}, 32'd0);
        chk("ar_pc_out", pc_out, 32'h0000_3000);
        chk("ar_ins", ins_out, 32'd0);
        chk("ar_addr", imem_addr, 32'h0000_3000);
        tick();
        reset    = 1'b1;
        model_pc = 32'h0000_3000;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFACE_FACE;
        tick();
        imem_rvalid = 1'b0;
        chk("late_req", {31'd0, imem_req}, 32'd1);
        chk("late_addr", imem_addr, 32'h0000_3000);
        chk("late_nvalid", {31'd0, out_valid}, 32'd0);
        chk("late_ins", ins_out, 32'd0);

        fetch("f2", 32'h1111_2222, 1, 0);
        accept(32'hFFFF_FFFC);
        fetch("f3", 32'h3333_4444, 0, 0);
        accept(32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_err", {31'd0, addr_err}, 32'd0);
        fetch("f4", 32'h5555_6666, 0, 2);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
